uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte-wide UART transmitter with a small input FIFO.
- Drives the SOC's `ftdi_txd` pin, which is currently tied to 0, and sits downstream of the processor/memory-mapped output path.
- Accepts bytes over a valid/ready handshake and serialises each as 8N1 (1 start, 8 data LSB-first, 1 stop) at a fixed baud rate derived from the system clock.

Parameters:
- CLK_FREQ_HZ, 25000000, frequency of `clk` in Hz.
- BAUD_RATE, 115200, line rate in bits/s; DIV = CLK_FREQ_HZ / BAUD_RATE (integer truncation) clock cycles per bit, DIV >= 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- resetn  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte; high iff FIFO not full.
- tx  output  1  serial line, idle high; connects to ftdi_txd.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes currently queued (excludes the byte being shifted).

Behaviour:
- Reset (resetn low, asynchronous):
  - tx=1, tx_ready=1, busy=0, fifo_count=0.
  - FSM=IDLE; FIFO pointers and baud counter cleared.
  - Asserting resetn low mid-frame aborts the frame immediately: tx returns high with no stop bit. Release is synchronous to clk.
- Push:
  - On a rising edge with tx_valid && tx_ready, tx_data is written at the write pointer and fifo_count increments.
  - tx_valid while full is ignored: no write, no error.
  - tx_data need only be stable in the accepting cycle.
- FSM states: IDLE, START, DATA, STOP. All outputs are registered.
  - IDLE: tx=1. If FIFO non-empty, pop head into the shift register, load baud counter = DIV-1, go to START.
    - tx goes low on the edge after the push edge (1-cycle latency from acceptance into an empty idle block).
  - START: tx=0 for exactly DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for DIV cycles per bit, shifting right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for exactly DIV cycles.
    - At the end, if FIFO non-empty, pop and go directly to START with no idle cycle.
    - Otherwise go to IDLE.
- Frame length is exactly 10*DIV cycles. Back-to-back frames are contiguous.
- Baud counter:
  - Down-counter reloaded to DIV-1 at each bit boundary; the bit ends when it reaches 0.
  - Wrap-around never occurs.
- Simultaneous push and pop in the same cycle: fifo_count is unchanged, and both pointers advance modulo FIFO_DEPTH.
- Push when full and a pop in the same cycle: no push, because tx_ready was low that cycle. tx_ready rises the cycle after the pop.
- busy = (FSM != IDLE) || (fifo_count != 0), registered or derived from registered state only.
- fifo_count ranges from 0 to FIFO_DEPTH. tx_ready = (fifo_count != FIFO_DEPTH).
- Pointer width is $clog2(FIFO_DEPTH), with natural wrap at FIFO_DEPTH.

Test Plan:
- All scenarios use CLK_FREQ_HZ=1000000 and BAUD_RATE=100000, giving DIV=10.
1. Reset: hold resetn=0 for 3 cycles, release -> tx=1, tx_ready=1, busy=0, fifo_count=0; tx stays 1 for 50 idle cycles.
2. Single byte 0x55 pushed at edge E0:
   - tx=0 during cycles E1..E10.
   - Data bits 1,0,1,0,1,0,1,0, each held 10 cycles.
   - Stop bit high for 10 cycles; busy falls at E101.
3. Push 0xA3, 0x0F, 0xFF, 0x00, 0x81 on consecutive cycles:
   - First pops immediately; the next four fill the FIFO (fifo_count reaches 4, tx_ready=0).
   - A 6th push of 0x77 while full is dropped.
   - The line shows exactly 5 contiguous frames (500 cycles) decoding to A3,0F,FF,00,81.
4. Simultaneous push/pop: with fifo_count=2, push a byte on the exact cycle STOP ends -> fifo_count stays 2 and the next frame starts with no idle gap.
5. Reset mid-frame: assert resetn=0 during data bit 3 of 0xC6 -> tx=1 asynchronously, fifo_count=0; after release, no residual frame is transmitted.
6. Random: 200 random bytes with random tx_valid gaps, decoded by a bench UART receiver -> byte stream identical and in order, no framing errors, busy low only when the line is idle and the FIFO is empty.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte-wide 8N1 UART transmitter fed by a small valid/ready input FIFO.
// Drives the board-level ftdi_txd line; the line idles high.
module uart_tx_fifo #(
   parameter int unsigned CLK_FREQ_HZ = 25000000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [7:0]                     tx_data,
   input  logic                           tx_valid,
   output logic                           tx_ready,
   output logic                           tx,
   output logic                           busy,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

   localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned BW  = $clog2(DIV);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift;

   logic            push_c;
   logic            pop_c;
   logic            bit_end_c;
   logic            active_nxt_c;
   logic [CW-1:0]   count_nxt_c;

   // Handshake, pop and occupancy decode from registered state.
   always_comb begin
      push_c       = tx_valid && tx_ready;
      bit_end_c    = (baud_cnt == BW'(0));
      pop_c        = (fifo_count != CW'(0)) &&
                     ((state == IDLE) || ((state == STOP) && bit_end_c));
      active_nxt_c = pop_c || ((state != IDLE) && !((state == STOP) && bit_end_c));
      count_nxt_c  = fifo_count;
      if (push_c && !pop_c) begin
         count_nxt_c = fifo_count + CW'(1);
      end else if (!push_c && pop_c) begin
         count_nxt_c = fifo_count - CW'(1);
      end
   end

   // FIFO storage; contents need no reset since occupancy guards every read.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   // FIFO pointers, occupancy and the registered status outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         tx_ready   <= 1'b1;
         busy       <= 1'b0;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         fifo_count <= count_nxt_c;
         tx_ready   <= (count_nxt_c != CW'(FIFO_DEPTH));
         busy       <= active_nxt_c || (count_nxt_c != CW'(0));
      end
   end

   // Frame sequencer: start bit, eight data bits LSB first, stop bit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         tx       <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop_c) begin
                  shift    <= mem[rd_ptr];
                  baud_cnt <= BW'(DIV - 1);
                  tx       <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end_c) begin
                  baud_cnt <= BW'(DIV - 1);
                  bit_idx  <= '0;
                  tx       <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt - BW'(1);
               end
            end
            DATA: begin
               if (bit_end_c) begin
                  baud_cnt <= BW'(DIV - 1);
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - BW'(1);
               end
            end
            STOP: begin
               if (bit_end_c) begin
                  // Chain straight into the next start bit when more data is queued.
                  if (pop_c) begin
                     shift    <= mem[rd_ptr];
                     baud_cnt <= BW'(DIV - 1);
                     tx       <= 1'b0;
                     state    <= START;
                  end else begin
                     tx    <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - BW'(1);
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and random bench for uart_tx_fifo with a line-decoding scoreboard.
module tb_uart_tx_fifo;

   localparam int unsigned CLK_HZ = 1000000;
   localparam int unsigned BAUD   = 100000;
   localparam int unsigned DEPTH  = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   bit         mon_on = 1'b0;
   logic [7:0] exp_q[$];
   int         starts[$];

   uart_tx_fifo #(
      .CLK_FREQ_HZ(CLK_HZ),
      .BAUD_RATE  (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx        (tx),
      .busy      (busy),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0) && n < limit) begin
         step();
         n++;
      end
      chk("drain_in_time", (n < limit) ? 1 : 0, 1);
   endtask

   // Line receiver: samples mid-bit on falling edges and checks against the queue.
   initial begin
      int         st;
      int         cnt;
      int         nb;
      logic [7:0] sh;
      st = 0; cnt = 0; nb = 0; sh = 8'h00;
      forever begin
         @(negedge clk);
         if (!resetn || !mon_on) begin
            st = 0;
         end else begin
            case (st)
               0: if (tx == 1'b0) begin
                     st = 1; cnt = 4; starts.push_back(cyc);
                  end
               1: if (cnt == 0) begin
                     chk("rx_start_bit", tx, 1'b0);
                     cnt = 9; nb = 0; st = 2;
                  end else cnt--;
               2: if (cnt == 0) begin
                     sh = {tx, sh[7:1]};
                     nb++; cnt = 9;
                     if (nb == 8) st = 3;
                  end else cnt--;
               default: if (cnt == 0) begin
                     chk("rx_stop_bit", tx, 1'b1);
                     if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rx_unexpected_byte: got %0h expected none", sh);
                     end else begin
                        chk("rx_byte", sh, exp_q.pop_front());
                     end
                     st = 0;
                  end else cnt--;
            endcase
         end
      end
   end

   // Status invariants checked every cycle outside reset.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on && resetn) begin
            chk("busy_low_needs_idle_line", (!busy && (tx !== 1'b1 || fifo_count != 3'd0)) ? 1 : 0, 0);
            chk("busy_high_when_queued", (fifo_count != 3'd0 && !busy) ? 1 : 0, 0);
            chk("ready_vs_count", tx_ready, (fifo_count != 3'd4) ? 1 : 0);
            chk("count_range", (fifo_count <= 3'd4) ? 1 : 0, 1);
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lows;
      int         errs;
      logic [9:0] fr;
      logic [7:0] t3 [5];
      logic [7:0] t4 [4];
      logic [7:0] b;
      logic       r;
      int         n;

      // 1: reset and idle line
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      step();
      chk("reset_tx", tx, 1);
      chk("reset_ready", tx_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_count", fifo_count, 0);
      mon_on = 1'b1;
      lows = 0;
      repeat (50) begin
         step();
         if (tx !== 1'b1) lows++;
      end
      chk("idle_low_cycles", lows, 0);

      // 2: single byte 0x55, cycle-exact waveform
      starts.delete();
      exp_q.push_back(8'h55);
      tx_data = 8'h55; tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      chk("t2_tx_before_start", tx, 1);
      chk("t2_busy_rise", busy, 1);
      chk("t2_count_after_push", fifo_count, 1);
      fr = {1'b1, 8'h55, 1'b0};
      errs = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (tx !== fr[(k - 1) / 10]) errs++;
      end
      chk("t2_waveform_errs", errs, 0);
      chk("t2_busy_last_stop", busy, 1);
      step();
      chk("t2_busy_fall", busy, 0);
      chk("t2_tx_idle", tx, 1);
      chk("t2_frames", starts.size(), 1);

      // 3: burst fills FIFO, push while full dropped
      wait_idle(1000);
      starts.delete();
      t3[0] = 8'hA3; t3[1] = 8'h0F; t3[2] = 8'hFF; t3[3] = 8'h00; t3[4] = 8'h81;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(t3[i]);
         tx_data = t3[i]; tx_valid = 1'b1;
         step();
      end
      chk("t3_count_full", fifo_count, 4);
      chk("t3_ready_low", tx_ready, 0);
      tx_data = 8'h77;
      step();
      tx_valid = 1'b0;
      chk("t3_count_after_drop", fifo_count, 4);
      chk("t3_ready_still_low", tx_ready, 0);
      wait_idle(1000);
      chk("t3_frames", starts.size(), 5);
      for (int i = 1; i < starts.size(); i++) chk("t3_frame_spacing", starts[i] - starts[i - 1], 100);

      // 4: push exactly when STOP ends with two queued
      starts.delete();
      t4[0] = 8'h3C; t4[1] = 8'h5A; t4[2] = 8'hE7; t4[3] = 8'h12;
      for (int i = 0; i < 4; i++) exp_q.push_back(t4[i]);
      tx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tx_data = t4[i];
         step();
      end
      tx_valid = 1'b0;
      chk("t4_count_before", fifo_count, 2);
      repeat (98) step();
      tx_data = t4[3]; tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      chk("t4_count_pushpop", fifo_count, 2);
      chk("t4_next_start_tx", tx, 0);
      wait_idle(1000);
      chk("t4_frames", starts.size(), 4);
      for (int i = 1; i < starts.size(); i++) chk("t4_frame_spacing", starts[i] - starts[i - 1], 100);

      // 5: reset during data bit 3 of 0xC6
      exp_q.push_back(8'hC6);
      tx_data = 8'hC6; tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      repeat (44) step();
      #3 resetn = 1'b0;
      #1;
      chk("t5_tx_async", tx, 1);
      chk("t5_count_async", fifo_count, 0);
      chk("t5_busy_async", busy, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      starts.delete();
      lows = 0;
      repeat (200) begin
         step();
         if (tx !== 1'b1) lows++;
      end
      chk("t5_no_residual_low", lows, 0);
      chk("t5_no_residual_frames", starts.size(), 0);
      chk("t5_busy_after", busy, 0);

      // 6: random bytes with random gaps
      starts.delete();
      for (int i = 0; i < 200; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         tx_data = b; tx_valid = 1'b1;
         n = 0;
         do begin
            r = tx_ready;
            step();
            n++;
         end while (!r && n < 5000);
         if (!r) chk("t6_accept_timeout", r, 1);
         tx_valid = 1'b0;
         tx_data = 8'($urandom_range(0, 255));
         repeat ($urandom_range(0, 3)) step();
      end
      wait_idle(30000);
      chk("t6_frames", starts.size(), 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
